rab_lookup_ctrl: RTL and testbench
==================================

# rab_lookup_ctrl

Parametrised lookup controller for the AXI remap address block (RAB). It arbitrates between N slave-side request ports and drives the shared lookup table for a configurable latency. It then issues a per-port accept or drop, and records the first faulting translation in a sticky error register with interrupt pulses. It sits between the RAB input ports and the slice/TLB lookup array, and replaces the fixed two-port controller.

## Interface
- N_PORTS, 2, number of request ports (≥1)
- ADDR_W, 32, width of the translated address
- LOOKUP_LAT, 2, cycles from grant to valid lookup flags (≥1)
- IDW (derived), max(1, $clog2(N_PORTS)), port index width

Ports:
- s_axi_aclk  in  1  clock; one clock domain
- s_axi_areset  in  1  reset, asynchronous, active-high
- port_addr_valid  in  N_PORTS  per-port request pending
- port_sent  in  N_PORTS  per-port: downstream transfer of the decided beat complete
- grant  out  N_PORTS  one-hot select of the address fed to the lookup array
- grant_id  out  IDW  binary index of grant
- no_hit, multiple_hit, no_prot  in  1 each  lookup result flags, valid on the last LOOKUP cycle
- out_addr  in  ADDR_W  translated address, valid with the flags
- port_accept, port_drop  out  N_PORTS  one-cycle decision pulses
- int_miss, int_multi, int_prot  out  1 each  one-cycle interrupt pulses
- err_valid, err_overflow  out  1 each  sticky error status
- err_addr  out  ADDR_W  out_addr of the first fault
- err_port  out  IDW  port index of the first fault
- err_cause  out  3  {prot, multi, miss} of the first fault
- err_clear  in  1  clears the sticky error status

## Operation
- States: IDLE, LOOKUP, DONE.
- IDLE, any port_addr_valid asserted:
  - round-robin pick, searching from rr_ptr upward with wrap;
  - register grant and grant_id;
  - load cnt = LOOKUP_LAT-1;
  - go to LOOKUP.
- IDLE, no request: grant stays 0.
- LOOKUP:
  - cnt decrements each cycle.
  - On the cycle cnt==0: sample the flags, compute fault = no_hit | multiple_hit | ~no_prot, go to DONE.
- DONE:
  - In the first DONE cycle, exactly one of port_accept[grant_id] or port_drop[grant_id] is high: drop when fault, accept otherwise.
  - The int_* pulses fire in the same cycle, each equal to its respective cause bit.
  - DONE exits to IDLE when port_sent[grant_id] is high.
  - port_sent on any other port is ignored.
  - On exit, rr_ptr = grant_id+1 mod N_PORTS and grant clears.
- grant and grant_id are held constant from LOOKUP entry until DONE exits.
- Deassertion of port_addr_valid after grant does not abort the transaction.
- Error capture on fault:
  - If err_valid=0: load err_addr/err_port/err_cause and set err_valid.
  - If err_valid=1: set err_overflow and keep the existing contents.
- err_clear clears err_valid and err_overflow.
- If err_clear coincides with a new fault, the new fault is captured, err_valid=1 and err_overflow=0.
- Reset (asynchronous, at any point including mid-transaction):
  - state=IDLE, rr_ptr=0, cnt=0;
  - all outputs 0, including err_* contents.
  - No pending accept, drop or interrupt pulse survives.
- N_PORTS=1: grant is always bit 0 and grant_id is always 0.

## Timing
- Request seen in IDLE at edge k → grant valid from cycle k+1.
- Flags sampled at cycle k+LOOKUP_LAT.
- Accept/drop and int pulses at cycle k+LOOKUP_LAT+1.
- Earliest port_sent is the same cycle as the decision pulse. The next grant then follows 2 cycles later, so the minimum request period is LOOKUP_LAT+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- err_* update in the cycle after the sample, together with the pulses.

## Structure
- Package rab_pkg:
  - state enum rab_lookup_state_e {IDLE, LOOKUP, DONE};
  - cause bit indices ERR_MISS=0, ERR_MULTI=1, ERR_PROT=2.
- Sub-module rab_rr_arbiter (N_PORTS):
  - inputs: request vector, rr_ptr;
  - outputs: one-hot grant, index, any.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- N_PORTS=2, LOOKUP_LAT=2, port 0 request, flags clean, out_addr=0x1234_0000 → grant=01 for 3 cycles, port_accept=01 pulse at k+3, no int, err_valid=0.
- Ports 0 and 1 request continuously, port_sent returned on the decision cycle → grants alternate 01,10,01, one grant every 4 cycles.
- Port 1, no_hit=1, out_addr=0xDEAD_BEEF → port_drop=10, int_miss pulse, err_valid=1, err_addr=0xDEADBEEF, err_port=1, err_cause=001.
- Second fault on port 0 (no_prot=0) while err_valid=1 → int_prot pulse, err_overflow=1, err_* unchanged. Then err_clear coincident with a third fault (multiple_hit) → err_cause=010, err_overflow=0.
- N_PORTS=4, LOOKUP_LAT=5:
  - port 2 granted;
  - port_sent[3] asserted in DONE → stays in DONE;
  - port_sent[2] → IDLE;
  - next simultaneous requests on 0 and 3 → port 3 granted first.
- s_axi_areset asserted mid-LOOKUP → all outputs 0 immediately. After release, a new request is granted with rr_ptr=0 (port 0 wins over port 1).

Source files
------------

// File: rtl/rab_pkg.sv
// Shared types and constants for the RAB lookup controller.
package rab_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DONE
  } rab_lookup_state_e;

  // Bit positions inside err_cause.
  localparam int unsigned ERR_MISS  = 0;
  localparam int unsigned ERR_MULTI = 1;
  localparam int unsigned ERR_PROT  = 2;

endpackage

// File: rtl/rab_rr_arbiter.sv
// Combinational round-robin picker: first request at or above rr_ptr, wrapping to port 0.
module rab_rr_arbiter #(
  parameter int unsigned N_PORTS = 2,
  localparam int unsigned IDW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               any
);

  logic [31:0] rr_ext;
  assign rr_ext = 32'(rr_ptr);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    // Upper segment first; the second pass only matters when nothing at/above rr_ptr asked.
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (!any && req[j] && (j >= rr_ext)) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        grant_id = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        grant_id = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rab_lookup_ctrl.sv
// Arbitrates N request ports onto the shared RAB lookup array, issues accept/drop and
// captures the first faulting translation in a sticky error register.
module rab_lookup_ctrl
  import rab_pkg::*;
#(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LOOKUP_LAT = 2,
  localparam int unsigned IDW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic [N_PORTS-1:0] port_addr_valid,
  input  logic [N_PORTS-1:0] port_sent,
  output logic [N_PORTS-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  input  logic               no_hit,
  input  logic               multiple_hit,
  input  logic               no_prot,
  input  logic [ADDR_W-1:0]  out_addr,
  output logic [N_PORTS-1:0] port_accept,
  output logic [N_PORTS-1:0] port_drop,
  output logic               int_miss,
  output logic               int_multi,
  output logic               int_prot,
  output logic               err_valid,
  output logic               err_overflow,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [IDW-1:0]     err_port,
  output logic [2:0]         err_cause,
  input  logic               err_clear
);

  localparam int unsigned CNTW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  rab_lookup_state_e  state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [N_PORTS-1:0] accept_q, accept_d, drop_q, drop_d;
  logic               int_miss_q, int_miss_d, int_multi_q, int_multi_d, int_prot_q, int_prot_d;
  logic               err_valid_q, err_valid_d, err_overflow_q, err_overflow_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic [IDW-1:0]     err_port_q, err_port_d;
  logic [2:0]         err_cause_q, err_cause_d;

  logic [N_PORTS-1:0] arb_grant;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;
  logic               sample, fault;
  logic [2:0]         cause;

  rab_rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arb (
    .req      (port_addr_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  always_comb begin
    cause            = '0;
    cause[ERR_MISS]  = no_hit;
    cause[ERR_MULTI] = multiple_hit;
    cause[ERR_PROT]  = ~no_prot;
    fault            = |cause;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    accept_d       = '0;
    drop_d         = '0;
    int_miss_d     = 1'b0;
    int_multi_d    = 1'b0;
    int_prot_d     = 1'b0;
    err_valid_d    = err_valid_q;
    err_overflow_d = err_overflow_q;
    err_addr_d     = err_addr_q;
    err_port_d     = err_port_q;
    err_cause_d    = err_cause_q;
    sample         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d    = arb_grant;
          grant_id_d = arb_id;
          cnt_d      = CNTW'(LOOKUP_LAT - 1);
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // grant_q is one-hot, so this only reacts to the granted port.
        if (|(port_sent & grant_q)) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          rr_ptr_d   = (grant_id_q == IDW'(N_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sample) begin
      accept_d    = fault ? '0 : grant_q;
      drop_d      = fault ? grant_q : '0;
      int_miss_d  = cause[ERR_MISS];
      int_multi_d = cause[ERR_MULTI];
      int_prot_d  = cause[ERR_PROT];
    end

    // A fault arriving with err_clear wins over the clear and starts a fresh record.
    if (sample && fault && (!err_valid_q || err_clear)) begin
      err_valid_d    = 1'b1;
      err_overflow_d = 1'b0;
      err_addr_d     = out_addr;
      err_port_d     = grant_id_q;
      err_cause_d    = cause;
    end else if (sample && fault) begin
      err_overflow_d = 1'b1;
    end else if (err_clear) begin
      err_valid_d    = 1'b0;
      err_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      grant_id_q     <= '0;
      accept_q       <= '0;
      drop_q         <= '0;
      int_miss_q     <= 1'b0;
      int_multi_q    <= 1'b0;
      int_prot_q     <= 1'b0;
      err_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_addr_q     <= '0;
      err_port_q     <= '0;
      err_cause_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      accept_q       <= accept_d;
      drop_q         <= drop_d;
      int_miss_q     <= int_miss_d;
      int_multi_q    <= int_multi_d;
      int_prot_q     <= int_prot_d;
      err_valid_q    <= err_valid_d;
      err_overflow_q <= err_overflow_d;
      err_addr_q     <= err_addr_d;
      err_port_q     <= err_port_d;
      err_cause_q    <= err_cause_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign port_accept  = accept_q;
  assign port_drop    = drop_q;
  assign int_miss     = int_miss_q;
  assign int_multi    = int_multi_q;
  assign int_prot     = int_prot_q;
  assign err_valid    = err_valid_q;
  assign err_overflow = err_overflow_q;
  assign err_addr     = err_addr_q;
  assign err_port     = err_port_q;
  assign err_cause    = err_cause_q;

endmodule

// File: tb/tb_rab_lookup_ctrl.sv
// Directed bench: a 2-port/latency-2 instance and a 4-port/latency-5 instance.
module tb_rab_lookup_ctrl;

  logic s_axi_aclk;
  logic s_axi_areset;

  // 2-port, LOOKUP_LAT=2
  logic [1:0]  a_valid, a_sent, a_grant, a_accept, a_drop;
  logic [0:0]  a_gid, a_err_port;
  logic        a_no_hit, a_multi, a_no_prot, a_err_clear;
  logic [31:0] a_out_addr, a_err_addr;
  logic        a_int_miss, a_int_multi, a_int_prot, a_err_valid, a_err_ovf;
  logic [2:0]  a_err_cause;

  // 4-port, LOOKUP_LAT=5
  logic [3:0]  b_valid, b_sent, b_grant, b_accept, b_drop;
  logic [1:0]  b_gid, b_err_port;
  logic [31:0] b_out_addr, b_err_addr;
  logic        b_int_miss, b_int_multi, b_int_prot, b_err_valid, b_err_ovf;
  logic [2:0]  b_err_cause;

  int errors = 0;
  int checks = 0;

  rab_lookup_ctrl #(
    .N_PORTS    (2),
    .ADDR_W     (32),
    .LOOKUP_LAT (2)
  ) u_dut_a (
    .s_axi_aclk      (s_axi_aclk),
    .s_axi_areset    (s_axi_areset),
    .port_addr_valid (a_valid),
    .port_sent       (a_sent),
    .grant           (a_grant),
    .grant_id        (a_gid),
    .no_hit          (a_no_hit),
    .multiple_hit    (a_multi),
    .no_prot         (a_no_prot),
    .out_addr        (a_out_addr),
    .port_accept     (a_accept),
    .port_drop       (a_drop),
    .int_miss        (a_int_miss),
    .int_multi       (a_int_multi),
    .int_prot        (a_int_prot),
    .err_valid       (a_err_valid),
    .err_overflow    (a_err_ovf),
    .err_addr        (a_err_addr),
    .err_port        (a_err_port),
    .err_cause       (a_err_cause),
    .err_clear       (a_err_clear)
  );

  rab_lookup_ctrl #(
    .N_PORTS    (4),
    .ADDR_W     (32),
    .LOOKUP_LAT (5)
  ) u_dut_b (
    .s_axi_aclk      (s_axi_aclk),
    .s_axi_areset    (s_axi_areset),
    .port_addr_valid (b_valid),
    .port_sent       (b_sent),
    .grant           (b_grant),
    .grant_id        (b_gid),
    .no_hit          (1'b0),
    .multiple_hit    (1'b0),
    .no_prot         (1'b1),
    .out_addr        (b_out_addr),
    .port_accept     (b_accept),
    .port_drop       (b_drop),
    .int_miss        (b_int_miss),
    .int_multi       (b_int_multi),
    .int_prot        (b_int_prot),
    .err_valid       (b_err_valid),
    .err_overflow    (b_err_ovf),
    .err_addr        (b_err_addr),
    .err_port        (b_err_port),
    .err_cause       (b_err_cause),
    .err_clear       (1'b0)
  );

  initial s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic step();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    s_axi_areset = 1'b1;
    a_valid = '0; a_sent = '0; a_no_hit = 0; a_multi = 0; a_no_prot = 1; a_err_clear = 0;
    a_out_addr = '0;
    b_valid = '0; b_sent = '0; b_out_addr = 32'h0000_5000;
    #2;
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_err_valid", 32'(a_err_valid), 32'h0);
    chk("rst_b_grant", 32'(b_grant), 32'h0);
    step();
    s_axi_areset = 1'b0;

    // Single clean request on port 0; valid dropped after grant must not abort.
    a_valid = 2'b01; a_out_addr = 32'h1234_0000;
    step();
    a_valid = 2'b00;
    chk("t1_grant_k1", 32'(a_grant), 32'h1);
    chk("t1_gid_k1", 32'(a_gid), 32'h0);
    step();
    chk("t1_grant_k2", 32'(a_grant), 32'h1);
    chk("t1_accept_early", 32'(a_accept), 32'h0);
    step();
    chk("t1_grant_k3", 32'(a_grant), 32'h1);
    chk("t1_accept", 32'(a_accept), 32'h1);
    chk("t1_drop", 32'(a_drop), 32'h0);
    chk("t1_ints", 32'({a_int_prot, a_int_multi, a_int_miss}), 32'h0);
    chk("t1_err_valid", 32'(a_err_valid), 32'h0);
    a_sent = 2'b01;
    step();
    a_sent = 2'b00;
    chk("t1_grant_idle", 32'(a_grant), 32'h0);
    chk("t1_accept_gone", 32'(a_accept), 32'h0);

    // Reset so rr_ptr restarts at 0, then both ports request continuously.
    s_axi_areset = 1'b1;
    #2;
    s_axi_areset = 1'b0;
    a_valid = 2'b11;
    for (int g = 0; g < 3; g++) begin
      logic [1:0] eg;
      eg = (g == 1) ? 2'b10 : 2'b01;
      step();
      chk("t2_grant", 32'(a_grant), 32'(eg));
      step();
      step();
      chk("t2_accept", 32'(a_accept), 32'(eg));
      a_sent = eg;
      step();
      a_sent = 2'b00;
      chk("t2_idle_gap", 32'(a_grant), 32'h0);
    end
    a_valid = 2'b00;

    // rr_ptr is now 1. Miss on port 1 becomes the first recorded fault.
    a_valid = 2'b10; a_no_hit = 1; a_out_addr = 32'hDEAD_BEEF;
    step();
    a_valid = 2'b00;
    step();
    step();
    chk("t3_drop", 32'(a_drop), 32'h2);
    chk("t3_accept", 32'(a_accept), 32'h0);
    chk("t3_ints", 32'({a_int_prot, a_int_multi, a_int_miss}), 32'h1);
    chk("t3_err_valid", 32'(a_err_valid), 32'h1);
    chk("t3_err_addr", a_err_addr, 32'hDEAD_BEEF);
    chk("t3_err_port", 32'(a_err_port), 32'h1);
    chk("t3_err_cause", 32'(a_err_cause), 32'h1);
    chk("t3_err_ovf", 32'(a_err_ovf), 32'h0);
    a_sent = 2'b10;
    step();
    a_sent = 2'b00;
    chk("t3_int_gone", 32'(a_int_miss), 32'h0);

    // Protection fault on port 0 while a record is held: overflow only.
    a_valid = 2'b01; a_no_hit = 0; a_no_prot = 0; a_out_addr = 32'h0000_1111;
    step();
    a_valid = 2'b00;
    step();
    step();
    chk("t4_drop", 32'(a_drop), 32'h1);
    chk("t4_ints", 32'({a_int_prot, a_int_multi, a_int_miss}), 32'h4);
    chk("t4_err_ovf", 32'(a_err_ovf), 32'h1);
    chk("t4_err_addr", a_err_addr, 32'hDEAD_BEEF);
    chk("t4_err_port", 32'(a_err_port), 32'h1);
    chk("t4_err_cause", 32'(a_err_cause), 32'h1);
    a_sent = 2'b01;
    step();
    a_sent = 2'b00;

    // Clear lands on the sample edge of a multi-hit fault on port 1.
    a_valid = 2'b10; a_no_prot = 1; a_multi = 1; a_out_addr = 32'h0BAD_F00D;
    step();
    a_valid = 2'b00;
    step();
    a_err_clear = 1;
    step();
    a_err_clear = 0;
    chk("t5_ints", 32'({a_int_prot, a_int_multi, a_int_miss}), 32'h2);
    chk("t5_err_valid", 32'(a_err_valid), 32'h1);
    chk("t5_err_ovf", 32'(a_err_ovf), 32'h0);
    chk("t5_err_cause", 32'(a_err_cause), 32'h2);
    chk("t5_err_addr", a_err_addr, 32'h0BAD_F00D);
    a_sent = 2'b10;
    step();
    a_sent = 2'b00; a_multi = 0;
    a_err_clear = 1;
    step();
    a_err_clear = 0;
    chk("t5_cleared", 32'({a_err_valid, a_err_ovf}), 32'h0);

    // rr_ptr=0: miss on port 0 leaves a record and moves rr_ptr to 1.
    a_valid = 2'b01; a_no_hit = 1; a_out_addr = 32'h0000_00AA;
    step();
    a_valid = 2'b00;
    step();
    step();
    chk("t6_err_valid", 32'(a_err_valid), 32'h1);
    a_sent = 2'b01;
    step();
    a_sent = 2'b00; a_no_hit = 0;

    // 4-port instance: foreign port_sent is ignored in DONE.
    b_valid = 4'b0100;
    step();
    b_valid = 4'b0000;
    chk("b_grant2", 32'(b_grant), 32'h4);
    chk("b_gid2", 32'(b_gid), 32'h2);
    for (int i = 0; i < 4; i++) step();
    chk("b_accept_early", 32'(b_accept), 32'h0);
    step();
    chk("b_accept", 32'(b_accept), 32'h4);
    b_sent = 4'b1000;
    step();
    chk("b_stay_done", 32'(b_grant), 32'h4);
    chk("b_accept_once", 32'(b_accept), 32'h0);
    b_sent = 4'b0100;
    step();
    b_sent = 4'b0000;
    chk("b_idle", 32'(b_grant), 32'h0);
    b_valid = 4'b1001;
    step();
    chk("b_rr_grant3", 32'(b_grant), 32'h8);
    chk("b_rr_gid3", 32'(b_gid), 32'h3);

    // Both instances mid-LOOKUP when reset strikes.
    a_valid = 2'b11;
    step();
    chk("t7_pre_grant", 32'(a_grant), 32'h2);
    step();
    #2;
    s_axi_areset = 1'b1;
    #1;
    chk("rst_mid_a_grant", 32'({a_grant, a_gid}), 32'h0);
    chk("rst_mid_a_err", 32'({a_err_valid, a_err_ovf, a_err_port, a_err_cause}), 32'h0);
    chk("rst_mid_a_addr", a_err_addr, 32'h0);
    chk("rst_mid_b_grant", 32'({b_grant, b_gid}), 32'h0);
    step();
    step();
    chk("rst_mid_pulses", 32'({a_accept, a_drop, a_int_miss, b_accept, b_drop}), 32'h0);
    s_axi_areset = 1'b0;
    step();
    chk("post_rst_a_grant", 32'(a_grant), 32'h1);
    chk("post_rst_b_grant", 32'(b_grant), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
